// File: rtl/debug_run_ctrl.sv
// Run-control sequencer for the on-screen debugger: debounced front-panel buttons,
// run/halt/single-step gating of the core clock enable, and an editable PC breakpoint.
module debug_run_ctrl #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [15:0] BP_RESET        = 16'h0100,
  parameter logic        START_RUN       = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_run,
  input  logic        btn_step,
  input  logic        btn_bp_en,
  input  logic        btn_digit_sel,
  input  logic        btn_digit_inc,
  input  logic        cpu_fetch,
  input  logic [15:0] cpu_pc,
  output logic        cpu_ce,
  output logic        halted,
  output logic        bp_en,
  output logic        bp_hit,
  output logic [15:0] bp_addr,
  output logic [1:0]  digit_sel
);

  localparam int NB     = 5;
  localparam int B_RUN  = 0;
  localparam int B_STEP = 1;
  localparam int B_BPEN = 2;
  localparam int B_SEL  = 3;
  localparam int B_INC  = 4;

  typedef enum logic [1:0] {S_RUN, S_STEP, S_HALT} state_t;
  localparam state_t RESET_STATE = START_RUN ? S_RUN : S_HALT;

  logic [NB-1:0] btn_raw, sync1, sync2, deb, press;
  logic [15:0]   cnt [NB];

  assign btn_raw = {btn_digit_inc, btn_digit_sel, btn_bp_en, btn_step, btn_run};

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order. The counter array is reset
  // too because a stale count would let a pre-reset bounce complete a press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      press <= '0;
      for (int i = 0; i < NB; i++) cnt[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      press <= '0;
      for (int i = 0; i < NB; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DEBOUNCE_CYCLES - 16'd1) begin
          cnt[i]   <= '0;
          deb[i]   <= sync2[i];
          press[i] <= sync2[i];  // only the rising debounced edge is a press
        end else begin
          cnt[i] <= cnt[i] + 16'd1;
        end
      end
    end
  end

  logic run_press, step_press;
  assign run_press  = press[B_RUN];
  assign step_press = press[B_STEP];

  state_t state, state_next;
  logic   skip, skip_next, bp_hit_next;
  logic   addr_match, bp_match, halt_req;

  assign addr_match = bp_en && (cpu_pc == bp_addr);
  assign bp_match   = cpu_fetch && !skip && addr_match;
  assign halt_req   = (state != S_HALT) && cpu_fetch && !skip &&
                      ((state == S_STEP) || addr_match);
  assign cpu_ce     = (state != S_HALT) && !halt_req && !((state == S_RUN) && run_press);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_next  = state;
    bp_hit_next = bp_hit;
    skip_next   = skip;
    if (cpu_fetch && cpu_ce) skip_next = 1'b0;
    case (state)
      S_RUN: begin
        if (halt_req || run_press) begin
          state_next  = S_HALT;
          bp_hit_next = bp_match;
        end
      end
      S_STEP: begin
        if (halt_req) begin
          state_next  = S_HALT;
          bp_hit_next = 1'b0;
        end
      end
      S_HALT: begin
        // The parked fetch must not re-trigger the halt we are leaving.
        if (run_press || step_press) begin
          state_next  = run_press ? S_RUN : S_STEP;
          skip_next   = cpu_fetch;
          bp_hit_next = 1'b0;
        end
      end
      default: state_next = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= RESET_STATE;
      halted <= !START_RUN;
      bp_hit <= 1'b0;
      skip   <= 1'b0;
    end else begin
      state  <= state_next;
      halted <= (state == S_HALT);
      bp_hit <= bp_hit_next;
      skip   <= skip_next;
    end
  end

  // Breakpoint editing is allowed in any state; nibbles wrap without carry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bp_en     <= 1'b0;
      bp_addr   <= BP_RESET;
      digit_sel <= 2'd0;
    end else begin
      if (press[B_BPEN]) bp_en <= !bp_en;
      if (press[B_SEL])  digit_sel <= digit_sel + 2'd1;
      if (press[B_INC]) begin
        case (digit_sel)
          2'd0:    bp_addr[15:12] <= bp_addr[15:12] + 4'd1;
          2'd1:    bp_addr[11:8]  <= bp_addr[11:8]  + 4'd1;
          2'd2:    bp_addr[7:4]   <= bp_addr[7:4]   + 4'd1;
          default: bp_addr[3:0]   <= bp_addr[3:0]   + 4'd1;
        endcase
      end
    end
  end

endmodule
